alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiplier controller that sequences the shared 16-bit combinational ALU.
- Drives the ALU operand and opcode inputs each cycle and captures its result, using only the ADD (000), SHR (110) and SHL (111) operations.
- Sits beside the ALU in the execute stage.
- Returns the low WIDTH bits of a×b over a valid/ready request/response pair.

Parameters:
- WIDTH, 16: operand/result width; must equal the ALU width.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request offered
- req_ready  output  1  block can accept a request
- req_a  input  WIDTH  multiplicand
- req_b  input  WIDTH  multiplier
- rsp_valid  output  1  product available
- rsp_ready  input  1  consumer takes product
- rsp_product  output  WIDTH  (a×b) mod 2^WIDTH
- alu_src1  output  WIDTH  to ALU src1
- alu_src2  output  WIDTH  to ALU src2
- alu_aopcode  output  3  to ALU aopcode
- alu_result  input  WIDTH  from ALU result (same-cycle combinational)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Internal registers: a_r, b_r, acc_r (WIDTH each), cnt_r (5 bits), state.
- States: IDLE, CHECK, ADD, SHL, SHR, DONE.
- Reset (async, any state, including mid-operation):
  - state=IDLE; a_r=b_r=acc_r=cnt_r=0.
  - Any in-flight request is dropped; no response is produced.
  - Output values in reset: req_ready=1, rsp_valid=0, rsp_product=0, alu_src1=0, alu_src2=0, alu_aopcode=000.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: a_r=req_a, b_r=req_b, acc_r=0, cnt_r=0, go to CHECK.
- CHECK (no ALU use; ALU outputs idle values):
  - If the termination condition holds, go to DONE.
  - Else if b_r[0]=1, go to ADD.
  - Else go to SHL.
- ADD: drive src1=acc_r, src2=a_r, aopcode=000; acc_r<=alu_result; go to SHL.
- SHL: drive src1=0, src2=a_r, aopcode=111; a_r<=alu_result; go to SHR.
- SHR: drive src1=0, src2=b_r, aopcode=110; b_r<=alu_result; cnt_r<=cnt_r+1; go to CHECK.
- DONE:
  - rsp_valid=1, rsp_product=acc_r, held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE.
  - req_ready=0 in DONE, so there is always at least one idle cycle between a response and the next acceptance.
- ALU outputs in IDLE, CHECK and DONE are src1=0, src2=0, aopcode=000.
- req_ready=0 in every state except IDLE.
- rsp_product=acc_r in DONE, 0 otherwise.
- Arithmetic:
  - All arithmetic is performed by the ALU, with wrap-around modulo 2^WIDTH.
  - Overflow is silently discarded.
  - The block contains no adder except the cnt_r incrementer.
- Termination condition: cnt_r==WIDTH (see Optional Feature for the early-exit variant).
- Latency, measured in rising edges from the accepting edge to the first rsp_valid cycle: 3k+p+1.
  - p = popcount(req_b).
  - k = number of iterations (WIDTH without the option; see option for the early-exit value).
- req_valid while busy is ignored (no accept). Request inputs are not sampled after acceptance.

Optional Feature:
- Macro: ALU_MUL_SEQ_ZERO_SKIP_EN.
- Defined:
  - The termination condition in CHECK is (b_r==0) || (cnt_r==WIDTH).
  - k = index of the highest set bit of req_b plus 1, or 0 when req_b=0.
  - Latency is data-dependent.
- Undefined:
  - Termination is cnt_r==WIDTH only; k=WIDTH.
  - Latency is 3·WIDTH+p+1 (49..65 for WIDTH=16).
- Products are identical in both builds.

Test Plan:
- a=3, b=5, rsp_ready=1 -> product 0x000F.
  - Latency 12 with ZERO_SKIP, 51 without.
  - ALU opcode trace with ZERO_SKIP: 000,111,110,111,110,000,111,110.
- a=0xFFFF, b=0xFFFF -> product 0x0001, latency 65 in both builds.
- a=0x1234, b=0 -> product 0x0000, latency 1 with ZERO_SKIP, 49 without; no ADD state visited.
- Backpressure: a=7, b=9, rsp_ready held 0 for 5 cycles after rsp_valid.
  - rsp_product=0x003F stable; req_ready=0 throughout; a second req_valid is not accepted until the cycle after the handshake.
- Reset: rst_n pulsed low mid-operation (e.g. in SHL of a=3, b=5).
  - All outputs return to reset values immediately, with no rsp_valid.
  - A subsequent request a=2, b=8 yields 0x0010.
- 1000 random (a,b) pairs with random rsp_ready stalls -> every product equals (a×b) mod 65536; latency matches formula.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that drives the shared execute-stage ALU.
// Optional ALU_MUL_SEQ_ZERO_SKIP_EN: stop iterating once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | ready for a request
// CHECK | choose next step: finish, add multiplicand, or shift only
// ADD   | acc_r <= acc_r + a_r through the ALU
// SHL   | a_r <= a_r << 1 through the ALU
// SHR   | b_r <= b_r >> 1 through the ALU, count one iteration
// DONE  | product presented until consumer takes it
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_product,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [2:0]       alu_aopcode,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHL   = 3'd3;
  localparam logic [2:0] S_SHR   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             done_cond;

`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
  assign done_cond = (b_r == '0) || (cnt_r == CW'(WIDTH));
`else
  assign done_cond = (cnt_r == CW'(WIDTH));
`endif

  assign req_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_DONE);
  assign rsp_product = rsp_valid ? acc_r : '0;

  // ALU sees zeros/ADD whenever this block is not actively using it
  always_comb begin
    alu_src1    = '0;
    alu_src2    = '0;
    alu_aopcode = OP_ADD;
    case (state)
      S_ADD: begin
        alu_src1    = acc_r;
        alu_src2    = a_r;
        alu_aopcode = OP_ADD;
      end
      S_SHL: begin
        alu_src2    = a_r;
        alu_aopcode = OP_SHL;
      end
      S_SHR: begin
        alu_src2    = b_r;
        alu_aopcode = OP_SHR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc_r <= '0;
      cnt_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_r   <= req_a;
            b_r   <= req_b;
            acc_r <= '0;
            cnt_r <= '0;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (done_cond)   state <= S_DONE;
          else if (b_r[0]) state <= S_ADD;
          else             state <= S_SHL;
        end
        S_ADD: begin
          acc_r <= alu_result;
          state <= S_SHL;
        end
        S_SHL: begin
          a_r   <= alu_result;
          state <= S_SHR;
        end
        S_SHR: begin
          b_r   <= alu_result;
          cnt_r <= cnt_r + CW'(1);
          state <= S_CHECK;
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
